// File: rtl/cp0_ctrl.sv
// Coprocessor-0: Status/Cause/EPC/BadVAddr/Count/Compare, interrupt request,
// commit-stage exception entry and ERET redirect.
module cp0_ctrl #(
    parameter int unsigned N_HWINT    = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter int unsigned TIMER_LINE = 5,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_HWINT-1:0] ext_int_i,
    input  logic               mtc0_we_i,
    input  logic [4:0]         mtc0_addr_i,
    input  logic [2:0]         mtc0_sel_i,
    input  logic [31:0]        mtc0_wdata_i,
    input  logic [4:0]         rd_addr_i,
    input  logic [2:0]         rd_sel_i,
    output logic [31:0]        rd_data_o,
    input  logic               exc_valid_i,
    input  logic [4:0]         exc_code_i,
    input  logic [31:0]        exc_pc_i,
    input  logic               exc_bd_i,
    input  logic               exc_bad_we_i,
    input  logic [31:0]        exc_badvaddr_i,
    input  logic               eret_i,
    output logic               int_req_o,
    output logic               flush_o,
    output logic [31:0]        flush_pc_o,
    output logic [31:0]        status_o,
    output logic [31:0]        cause_o,
    output logic [31:0]        epc_o
);

    localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    localparam logic [4:0] AddrBadVAddr = 5'd8;
    localparam logic [4:0] AddrCount    = 5'd9;
    localparam logic [4:0] AddrCompare  = 5'd11;
    localparam logic [4:0] AddrStatus   = 5'd12;
    localparam logic [4:0] AddrCause    = 5'd13;
    localparam logic [4:0] AddrEpc      = 5'd14;

    logic [N_HWINT-1:0] ext_q;
    logic [7:0]         im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               bd_q, bd_d;
    logic               ti_q, ti_d;
    logic [1:0]         ipsw_q, ipsw_d;
    logic [4:0]         exccode_q, exccode_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        badvaddr_q, badvaddr_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic [DivW-1:0]    div_q, div_d;

    logic       tick;
    logic       wr_en;
    logic       wr_count;
    logic       wr_compare;
    logic [5:0] ip_hw;

    assign tick       = (div_q == DivW'(COUNT_DIV - 1));
    // Writes lose to a same-cycle exception or ERET.
    assign wr_en      = mtc0_we_i & ~exc_valid_i & ~eret_i & (mtc0_sel_i == 3'd0);
    assign wr_count   = wr_en & (mtc0_addr_i == AddrCount);
    assign wr_compare = wr_en & (mtc0_addr_i == AddrCompare);

    always_comb begin
        ip_hw = '0;
        for (int i = 0; i < N_HWINT; i++) begin
            ip_hw[i] = ext_q[i];
        end
        ip_hw[TIMER_LINE] = ip_hw[TIMER_LINE] | ti_q;
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ipsw_d     = ipsw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        div_d      = tick ? '0 : div_q + DivW'(1);
        count_d    = tick ? count_q + 32'd1 : count_q;

        if (wr_count) begin
            count_d = mtc0_wdata_i;
            div_d   = '0;
        end
        if (wr_compare) begin
            compare_d = mtc0_wdata_i;
            ti_d      = 1'b0;
        end
        // Match against the pre-write Compare; a match outranks the clear.
        if ((tick || wr_count) && (count_d == compare_q)) begin
            ti_d = 1'b1;
        end

        if (exc_valid_i) begin
            if (!exl_q) begin
                epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            exccode_d = exc_code_i;
            exl_d     = 1'b1;
            if (exc_bad_we_i) begin
                badvaddr_d = exc_badvaddr_i;
            end
        end else if (eret_i) begin
            exl_d = 1'b0;
        end else if (wr_en) begin
            case (mtc0_addr_i)
                AddrStatus: begin
                    im_d  = mtc0_wdata_i[15:8];
                    exl_d = mtc0_wdata_i[1];
                    ie_d  = mtc0_wdata_i[0];
                end
                AddrCause: ipsw_d = mtc0_wdata_i[9:8];
                AddrEpc:   epc_d  = mtc0_wdata_i;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ipsw_q     <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            div_q      <= '0;
        end else begin
            ext_q      <= ext_int_i;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ipsw_q     <= ipsw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            div_q      <= div_d;
        end
    end

    assign status_o  = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o   = {bd_q, ti_q, 14'b0, ip_hw, ipsw_q, 1'b0, exccode_q, 2'b0};
    assign epc_o     = epc_q;
    assign int_req_o = ie_q & ~exl_q & (|({ip_hw, ipsw_q} & im_q));

    assign flush_o    = exc_valid_i | eret_i;
    assign flush_pc_o = exc_valid_i ? EXC_VECTOR : (eret_i ? epc_q : 32'd0);

    always_comb begin
        rd_data_o = '0;
        if (rd_sel_i == 3'd0) begin
            case (rd_addr_i)
                AddrBadVAddr: rd_data_o = badvaddr_q;
                AddrCount:    rd_data_o = count_q;
                AddrCompare:  rd_data_o = compare_q;
                AddrStatus:   rd_data_o = status_o;
                AddrCause:    rd_data_o = cause_o;
                AddrEpc:      rd_data_o = epc_q;
                default:      rd_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a field-level reference model.
module tb_cp0_ctrl;

    localparam int unsigned N_HWINT    = 6;
    localparam int unsigned COUNT_DIV  = 2;
    localparam int unsigned TIMER_LINE = 5;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_HWINT-1:0] ext_int = '0;
    logic               mtc0_we = 1'b0;
    logic [4:0]         mtc0_addr = '0;
    logic [2:0]         mtc0_sel = '0;
    logic [31:0]        mtc0_wdata = '0;
    logic [4:0]         rd_addr = '0;
    logic [2:0]         rd_sel = '0;
    logic [31:0]        rd_data;
    logic               exc_valid = 1'b0;
    logic [4:0]         exc_code = '0;
    logic [31:0]        exc_pc = '0;
    logic               exc_bd = 1'b0;
    logic               exc_bad_we = 1'b0;
    logic [31:0]        exc_badvaddr = '0;
    logic               eret = 1'b0;
    logic               int_req;
    logic               flush;
    logic [31:0]        flush_pc;
    logic [31:0]        status_o;
    logic [31:0]        cause_o;
    logic [31:0]        epc_o;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    cp0_ctrl #(
        .N_HWINT   (N_HWINT),
        .COUNT_DIV (COUNT_DIV),
        .TIMER_LINE(TIMER_LINE),
        .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ext_int_i     (ext_int),
        .mtc0_we_i     (mtc0_we),
        .mtc0_addr_i   (mtc0_addr),
        .mtc0_sel_i    (mtc0_sel),
        .mtc0_wdata_i  (mtc0_wdata),
        .rd_addr_i     (rd_addr),
        .rd_sel_i      (rd_sel),
        .rd_data_o     (rd_data),
        .exc_valid_i   (exc_valid),
        .exc_code_i    (exc_code),
        .exc_pc_i      (exc_pc),
        .exc_bd_i      (exc_bd),
        .exc_bad_we_i  (exc_bad_we),
        .exc_badvaddr_i(exc_badvaddr),
        .eret_i        (eret),
        .int_req_o     (int_req),
        .flush_o       (flush),
        .flush_pc_o    (flush_pc),
        .status_o      (status_o),
        .cause_o       (cause_o),
        .epc_o         (epc_o)
    );

    always #5 clk = ~clk;

    // Reference model: architectural fields; Count is base + elapsed/COUNT_DIV.
    logic [31:0] m_im, m_exl, m_ie, m_bd, m_ti, m_ipsw, m_exc;
    logic [31:0] m_epc, m_bad, m_base, m_cmp, m_ext;
    int unsigned m_elapsed;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_elapsed / COUNT_DIV);
    endfunction

    function automatic logic [31:0] m_ip();
        logic [31:0] hw;
        hw = m_ext & ((32'd1 << N_HWINT) - 32'd1);
        if (m_ti != 0) hw = hw | (32'd1 << TIMER_LINE);
        return (hw << 2) | m_ipsw;
    endfunction

    function automatic logic [31:0] e_status();
        return 32'h00400000 | (m_im << 8) | (m_exl << 1) | m_ie;
    endfunction

    function automatic logic [31:0] e_cause();
        return (m_bd << 31) | (m_ti << 30) | (m_ip() << 8) | (m_exc << 2);
    endfunction

    function automatic logic [31:0] e_int_req();
        return ((m_ie != 0) && (m_exl == 0) && ((m_ip() & m_im) != 0)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] e_rd();
        if (rd_sel != 0) return 32'd0;
        case (rd_addr)
            5'd8:    return m_bad;
            5'd9:    return m_count();
            5'd11:   return m_cmp;
            5'd12:   return e_status();
            5'd13:   return e_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        logic [31:0] old_c, new_c;
        bit wr, upd, set_ti;
        if (rst) begin
            m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ipsw = 0; m_exc = 0;
            m_epc = 0; m_bad = 0; m_base = 0; m_cmp = 0; m_ext = 0; m_elapsed = 0;
            return;
        end
        old_c = m_count();
        m_elapsed++;
        new_c = m_count();
        upd = (new_c != old_c);
        wr = mtc0_we && !exc_valid && !eret && (mtc0_sel == 0);
        if (wr && mtc0_addr == 5'd9) begin
            m_base = mtc0_wdata;
            m_elapsed = 0;
            new_c = mtc0_wdata;
            upd = 1'b1;
        end
        set_ti = upd && (new_c == m_cmp);
        if (wr && mtc0_addr == 5'd11) begin
            m_cmp = mtc0_wdata;
            m_ti = 0;
        end
        if (set_ti) m_ti = 1;
        if (exc_valid) begin
            if (m_exl == 0) begin
                m_epc = exc_bd ? exc_pc - 4 : exc_pc;
                m_bd = {31'b0, exc_bd};
            end
            m_exc = {27'b0, exc_code};
            m_exl = 1;
            if (exc_bad_we) m_bad = exc_badvaddr;
        end else if (eret) begin
            m_exl = 0;
        end else if (wr) begin
            if (mtc0_addr == 5'd12) begin
                m_im = {24'b0, mtc0_wdata[15:8]};
                m_exl = {31'b0, mtc0_wdata[1]};
                m_ie = {31'b0, mtc0_wdata[0]};
            end else if (mtc0_addr == 5'd13) begin
                m_ipsw = {30'b0, mtc0_wdata[9:8]};
            end else if (mtc0_addr == 5'd14) begin
                m_epc = mtc0_wdata;
            end
        end
        m_ext = {{(32 - N_HWINT){1'b0}}, ext_int};
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %08h expected %08h", nm, $time, act, exp);
        end
    endtask

    // Cycle compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_data", rd_data, e_rd());
            chk("int_req", {31'b0, int_req}, e_int_req());
            chk("flush", {31'b0, flush}, (exc_valid || eret) ? 32'd1 : 32'd0);
            chk("flush_pc", flush_pc, exc_valid ? EXC_VECTOR : (eret ? m_epc : 32'd0));
            chk("status", status_o, e_status());
            chk("cause", cause_o, e_cause());
            chk("epc", epc_o, m_epc);
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; mtc0_addr = a; mtc0_sel = 3'd0; mtc0_wdata = d;
        step();
        mtc0_we = 1'b0;
    endtask

    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic bad_we, input logic [31:0] bad);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
        exc_bad_we = bad_we; exc_badvaddr = bad;
        #1;
        chk("exc_flush", {31'b0, flush}, 32'd1);
        chk("exc_flush_pc", flush_pc, 32'hBFC00380);
        step();
        exc_valid = 1'b0; exc_bad_we = 1'b0; exc_bd = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] prev, saved_epc;
        bit seen;
        logic [4:0] addrs [7];

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_status", status_o, 32'h00400000);
        chk("reset_cause", cause_o, 32'h0);

        repeat (10) step();
        rd_addr = 5'd9; #1;
        chk("count_after_10", rd_data, 32'd5);
        rd_addr = 5'd12; #1;
        chk("read_status", rd_data, 32'h00400000);

        // IM2 with a software IP0 request: mask does not match.
        mtc0(5'd12, 32'h00000401);
        mtc0(5'd13, 32'h00000100);
        chk("int_req_masked", {31'b0, int_req}, 32'd0);
        mtc0(5'd12, 32'h00000101);
        chk("int_req_sw", {31'b0, int_req}, 32'd1);

        do_exc(5'd0, 32'hBFC00100, 1'b0, 1'b0, 32'd0);
        chk("exc_epc", epc_o, 32'hBFC00100);
        chk("exc_status", status_o, 32'h00400103);
        chk("exc_int_req", {31'b0, int_req}, 32'd0);

        do_exc(5'd8, 32'h80001000, 1'b0, 1'b0, 32'd0);
        chk("nested_epc", epc_o, 32'hBFC00100);
        chk("nested_cause", cause_o, 32'h00000120);

        saved_epc = epc_o;
        eret = 1'b1; #1;
        chk("eret_flush_pc", flush_pc, 32'hBFC00100);
        step();
        eret = 1'b0; #1;
        chk("eret_status", status_o, 32'h00400101);

        do_exc(5'd4, 32'h80000104, 1'b1, 1'b1, 32'h80000003);
        chk("ds_epc", epc_o, 32'h80000100);
        chk("ds_cause", cause_o, 32'h80000110);
        rd_addr = 5'd8; #1;
        chk("ds_badvaddr", rd_data, 32'h80000003);
        eret = 1'b1;
        step();
        eret = 1'b0;

        mtc0(5'd12, (32'd1 << (10 + TIMER_LINE)) | 32'd1);
        mtc0(5'd13, 32'd0);
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd0);
        rd_addr = 5'd9; #1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (int_req) seen = 1'b1;
            else step();
        end
        chk("timer_fired", {31'b0, seen}, 32'd1);
        chk("timer_count", rd_data, 32'd20);
        chk("timer_ti", {31'b0, cause_o[30]}, 32'd1);
        mtc0(5'd11, 32'd1000);
        chk("ti_cleared", {31'b0, cause_o[30]}, 32'd0);
        chk("ti_int_req", {31'b0, int_req}, 32'd0);

        ext_int = 6'b000001; #1;
        chk("ext_before", {31'b0, cause_o[10]}, 32'd0);
        step();
        ext_int = '0; #1;
        chk("ext_latched", {31'b0, cause_o[10]}, 32'd1);
        step();
        chk("ext_dropped", {31'b0, cause_o[10]}, 32'd0);

        // Align to a tick: after a Count change, the second following edge ticks.
        prev = rd_data;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (rd_data != prev) seen = 1'b1;
        end
        chk("count_moving", {31'b0, seen}, 32'd1);
        step();
        mtc0(5'd9, 32'h00001234);
        chk("cnt_wr_tick", rd_data, 32'h00001234);
        step();
        chk("cnt_wr_hold", rd_data, 32'h00001234);
        step();
        chk("cnt_wr_inc", rd_data, 32'h00001235);

        mtc0(5'd9, 32'hFFFFFFFF);
        step();
        step();
        chk("count_wrap", rd_data, 32'd0);

        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst = ($urandom_range(0, 299) == 0);
            ext_int = N_HWINT'($urandom);
            rd_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 5)];
            rd_sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            r = $urandom_range(0, 99);
            exc_valid = (r < 6);
            eret = (r >= 6 && r < 12) || (r < 2);
            exc_code = 5'($urandom);
            exc_pc = $urandom;
            exc_bd = 1'($urandom);
            exc_bad_we = 1'($urandom);
            exc_badvaddr = $urandom;
            mtc0_we = ($urandom_range(0, 3) == 0);
            mtc0_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 5)];
            mtc0_sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            mtc0_wdata = $urandom;
            if (mtc0_addr == 5'd11 && $urandom_range(0, 1) == 1)
                mtc0_wdata = m_count() + 32'($urandom_range(0, 6));
            step();
        end
        rst = 1'b0; mtc0_we = 1'b0; exc_valid = 1'b0; eret = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
